// File: rtl/ola_capture.sv
// Logic-analyser capture buffer: circular RAM filled while armed, frozen a programmed
// number of samples after the trigger, then streamed out oldest-first over valid/ready.
module ola_capture #(
  parameter int sample_width = 8,
  parameter int addr_width   = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [sample_width-1:0] in_sample,
  input  logic                    in_trigger,
  input  logic                    cfg_arm,
  input  logic                    cfg_abort,
  input  logic [addr_width:0]     cfg_post_count,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [sample_width-1:0] rd_data,
  output logic                    rd_last,
  output logic [1:0]              out_state,
  output logic [addr_width:0]     out_count,
  output logic                    out_done
);

  typedef enum logic [1:0] {
    st_idle    = 2'd0,
    st_capture = 2'd1,
    st_post    = 2'd2,
    st_read    = 2'd3
  } state_t;

  localparam logic [addr_width:0]   depth_c    = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width-1:0] max_post_c = {addr_width{1'b1}};
  localparam logic [addr_width-1:0] one_a_c    = {{(addr_width-1){1'b0}}, 1'b1};
  localparam logic [addr_width:0]   one_c_c    = {{addr_width{1'b0}}, 1'b1};

  logic [sample_width-1:0] mem_q [0:(1<<addr_width)-1];

  state_t                  state_q, state_d;
  logic [addr_width-1:0]   wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0]   rd_ptr_q, rd_ptr_d;
  logic [addr_width-1:0]   post_q, post_d;
  logic [addr_width-1:0]   remain_q, remain_d;
  logic [addr_width:0]     count_q, count_d;
  logic [addr_width:0]     rd_left_q, rd_left_d;
  logic                    wait_q, wait_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic                    done_q, done_d;
  logic [sample_width-1:0] rd_data_q, rd_data_d;
  logic                    wr_en;
  logic                    load;
  logic                    xfer;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    post_d     = post_q;
    remain_d   = remain_q;
    count_d    = count_q;
    rd_left_d  = rd_left_q;
    wait_d     = wait_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    load       = 1'b0;
    xfer       = rd_valid_q & rd_ready;

    if (cfg_abort) begin
      state_d    = st_idle;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      wait_d     = 1'b0;
    end else begin
      case (state_q)
        st_idle: begin
          if (cfg_arm) begin
            wr_ptr_d = '0;
            count_d  = '0;
            post_d   = (cfg_post_count > {1'b0, max_post_c}) ? max_post_c
                                                               : cfg_post_count[addr_width-1:0];
            state_d  = st_capture;
          end
        end
        st_capture: begin
          if (in_valid) begin
            wr_en = 1'b1;
            if (in_trigger) begin
              if (post_q == '0) begin
                state_d = st_read;
                wait_d  = 1'b1;
              end else begin
                remain_d = post_q;
                state_d  = st_post;
              end
            end
          end
        end
        st_post: begin
          if (in_valid) begin
            wr_en    = 1'b1;
            remain_d = remain_q - one_a_c;
            if (remain_q == one_a_c) begin
              state_d = st_read;
              wait_d  = 1'b1;
            end
          end
        end
        st_read: begin
          // First READ cycle only positions the read pointer on the oldest stored word.
          if (wait_q) begin
            wait_d    = 1'b0;
            rd_ptr_d  = wr_ptr_q - count_q[addr_width-1:0];
            rd_left_d = count_q;
          end else begin
            load = (rd_left_q != '0) && (!rd_valid_q || rd_ready);
            if (load) begin
              rd_data_d  = mem_q[rd_ptr_q];
              rd_valid_d = 1'b1;
              rd_last_d  = (rd_left_q == one_c_c);
              rd_ptr_d   = rd_ptr_q + one_a_c;
              rd_left_d  = rd_left_q - one_c_c;
            end else if (xfer) begin
              rd_valid_d = 1'b0;
              rd_last_d  = 1'b0;
              if (rd_last_q) begin
                done_d  = 1'b1;
                state_d = st_idle;
              end
            end
          end
        end
        default: state_d = st_idle;
      endcase

      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + one_a_c;
        count_d  = (count_q == depth_c) ? count_q : count_q + one_c_c;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= st_idle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_q     <= '0;
      remain_q   <= '0;
      count_q    <= '0;
      rd_left_q  <= '0;
      wait_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_q     <= post_d;
      remain_q   <= remain_d;
      count_q    <= count_d;
      rd_left_q  <= rd_left_d;
      wait_q     <= wait_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
    end
  end

  // Sample RAM has no reset; its contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_sample;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign out_state = state_q;
  assign out_count = count_q;
  assign out_done  = done_q;

endmodule

// File: tb/tb_ola_capture.sv
// Self-checking bench for ola_capture: random capture/readout against a queue-based
// model of the recorded history, plus the directed wrap, clamp, abort and reset cases.
module tb_ola_capture;
  localparam int sw    = 8;
  localparam int aw    = 4;
  localparam int depth = 16;

  logic          clock, reset;
  logic          in_valid, in_trigger, cfg_arm, cfg_abort, rd_ready;
  logic [sw-1:0] in_sample;
  logic [aw:0]   cfg_post_count;
  logic          rd_valid, rd_last, out_done;
  logic [sw-1:0] rd_data;
  logic [1:0]    out_state;
  logic [aw:0]   out_count;

  int            n_cmp, n_bad;
  int            m_state, m_post, m_remain;
  logic [sw-1:0] hist[$];

  ola_capture #(.sample_width(sw), .addr_width(aw)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_sample(in_sample),
    .in_trigger(in_trigger), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
    .cfg_post_count(cfg_post_count), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .out_state(out_state),
    .out_count(out_count), .out_done(out_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    return (hist.size() > depth) ? depth : hist.size();
  endfunction

  // One clock: update the history model from the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clock);
    if (cfg_abort) begin
      m_state = 0;
    end else if (m_state == 0) begin
      if (cfg_arm) begin
        hist.delete();
        m_post  = (int'(cfg_post_count) > depth - 1) ? depth - 1 : int'(cfg_post_count);
        m_state = 1;
      end
    end else if (m_state == 1 || m_state == 2) begin
      if (in_valid) begin
        hist.push_back(in_sample);
        if (m_state == 1 && in_trigger) begin
          if (m_post == 0) m_state = 3;
          else begin
            m_remain = m_post;
            m_state  = 2;
          end
        end else if (m_state == 2) begin
          m_remain--;
          if (m_remain == 0) m_state = 3;
        end
      end
    end
    @(negedge clock);
    check("state", 32'(out_state), 32'(m_state));
    check("count", 32'(out_count), 32'(m_count()));
  endtask

  task automatic arm(input int post);
    cfg_arm = 1'b1;
    cfg_post_count = (aw+1)'(post);
    tick();
    cfg_arm = 1'b0;
  endtask

  task automatic send(input logic [sw-1:0] s, input bit v, input bit t);
    in_valid = v;
    in_sample = s;
    in_trigger = t;
    tick();
    in_valid = 1'b0;
    in_trigger = 1'b0;
  endtask

  task automatic seq_capture(input int post, input int n, input int trig);
    arm(post);
    for (int i = 0; i < n && m_state != 3; i++) send(sw'(i), 1'b1, i == trig);
  endtask

  // Random capture: gaps in in_valid, triggers on idle cycles and during POST that must be ignored.
  task automatic rand_capture(input int post);
    bit v, t;
    arm(post);
    for (int c = 0; c < 300 && m_state != 3; c++) begin
      v = ($urandom_range(3) != 0);
      t = (m_state == 1) ? ($urandom_range(9) == 0) : ($urandom_range(2) == 0);
      send(sw'($urandom), v, t);
    end
    if (m_state != 3) check("capture_timeout", 32'(0), 32'(1));
  endtask

  // Called at the negedge right after READ was entered; drains the window with random ready.
  task automatic read_out(input int pct);
    logic [sw-1:0] exp_q[$];
    logic [sw-1:0] pd;
    logic          pv, pl;
    int            n, got, first_cyc;
    bit            fin;
    n = m_count();
    for (int i = hist.size() - n; i < hist.size(); i++) exp_q.push_back(hist[i]);
    check("read_count", 32'(out_count), 32'(n));
    check("rd_valid_entry", 32'(rd_valid), 32'(0));
    got = 0; first_cyc = -1; fin = 1'b0;
    pv = rd_valid; pd = rd_data; pl = rd_last;
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      rd_ready = ($urandom_range(99) < pct);
      in_valid = $urandom_range(1) != 0;
      in_sample = sw'($urandom);
      @(posedge clock);
      @(negedge clock);
      if (pv && rd_ready) begin
        if (got < n) check("rd_data", 32'(pd), 32'(exp_q[got]));
        check("rd_last", 32'(pl), 32'(got == n - 1));
        got++;
        if (got == n) begin
          check("done_pulse", 32'(out_done), 32'(1));
          check("idle_after", 32'(out_state), 32'(0));
          check("valid_after", 32'(rd_valid), 32'(0));
          fin = 1'b1;
        end else check("no_done", 32'(out_done), 32'(0));
      end else begin
        if (pv) begin
          check("stall_valid", 32'(rd_valid), 32'(1));
          check("stall_data", 32'(rd_data), 32'(pd));
          check("stall_last", 32'(rd_last), 32'(pl));
        end
        check("no_done", 32'(out_done), 32'(0));
      end
      if (!fin) begin
        check("read_state", 32'(out_state), 32'(3));
        check("read_hold_count", 32'(out_count), 32'(n));
        if (rd_valid) check("last_flag", 32'(rd_last), 32'(got == n - 1));
        if (first_cyc < 0 && rd_valid) begin
          first_cyc = cyc;
          check("first_latency", 32'(cyc), 32'(2));
        end
      end
      pv = rd_valid; pd = rd_data; pl = rd_last;
    end
    if (!fin) check("read_timeout", 32'(0), 32'(1));
    rd_ready = 1'b0;
    in_valid = 1'b0;
    m_state = 0;
    @(posedge clock);
    @(negedge clock);
    check("done_one_cycle", 32'(out_done), 32'(0));
    check("idle_stays", 32'(out_state), 32'(0));
  endtask

  initial begin
    int sent;
    n_cmp = 0; n_bad = 0; m_state = 0; m_post = 0; m_remain = 0;
    reset = 1'b1; in_valid = 1'b0; in_trigger = 1'b0; cfg_arm = 1'b0; cfg_abort = 1'b0;
    rd_ready = 1'b0; in_sample = '0; cfg_post_count = '0;
    repeat (2) @(negedge clock);
    check("rst_state", 32'(out_state), 32'(0));
    check("rst_count", 32'(out_count), 32'(0));
    check("rst_valid", 32'(rd_valid), 32'(0));
    check("rst_last", 32'(rd_last), 32'(0));
    check("rst_done", 32'(out_done), 32'(0));
    check("rst_data", 32'(rd_data), 32'(0));
    reset = 1'b0;

    seq_capture(3, 9, 5);
    read_out(100);
    seq_capture(4, 30, 25);
    read_out(100);
    arm(0);
    send(8'd7, 1'b1, 1'b0);
    send(8'd8, 1'b1, 1'b1);
    read_out(100);

    // Post count 20 must behave as 15 on a 16-deep buffer.
    arm(20);
    sent = 0;
    for (int i = 0; i < 40 && m_state != 3; i++) begin
      send(sw'(i + 100), 1'b1, i == 2);
      sent++;
    end
    check("clamp_post", 32'(sent - 3), 32'(15));
    read_out(70);

    repeat (6) begin
      rand_capture($urandom_range(20));
      read_out(50);
    end

    // Abort with simultaneous arm while in POST.
    arm(5);
    send(8'd1, 1'b1, 1'b0);
    send(8'd2, 1'b1, 1'b1);
    send(8'd3, 1'b1, 1'b0);
    cfg_abort = 1'b1; cfg_arm = 1'b1;
    tick();
    cfg_abort = 1'b0; cfg_arm = 1'b0;
    repeat (3) begin
      tick();
      check("abort_valid", 32'(rd_valid), 32'(0));
      check("abort_done", 32'(out_done), 32'(0));
    end
    arm(3);
    check("rearm_count", 32'(out_count), 32'(0));
    for (int i = 0; i < 9 && m_state != 3; i++) send(sw'(i), 1'b1, i == 5);
    read_out(100);

    // Asynchronous reset in the middle of a readout.
    seq_capture(3, 9, 5);
    rd_ready = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("pre_reset_valid", 32'(rd_valid), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("areset_valid", 32'(rd_valid), 32'(0));
    check("areset_state", 32'(out_state), 32'(0));
    check("areset_count", 32'(out_count), 32'(0));
    @(negedge clock);
    reset = 1'b0; rd_ready = 1'b0;
    m_state = 0; hist.delete();
    seq_capture(3, 9, 5);
    read_out(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
